// File: rtl/mem_burst_responder.sv
// mem_burst_responder: on-chip RAM serving single-word writes and fixed-length burst reads; ports: i_clk, i_reset_n (sync, active low), i_mem_addr/i_mem_in/i_mem_wrreq/i_mem_rdreq in, o_mem_out/o_mem_out_valid/o_mem_burstlen out
module mem_burst_responder #(
  parameter int DATABITS    = 32,
  parameter int ADDRBITS    = 32,
  parameter int MEMWORDBITS = 10,
  parameter int BURSTLEN    = 16,
  parameter int RDLATENCY   = 2
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [ADDRBITS-1:0] i_mem_addr,
  input  logic [DATABITS-1:0] i_mem_in,
  input  logic                i_mem_wrreq,
  input  logic                i_mem_rdreq,
  output logic [DATABITS-1:0] o_mem_out,
  output logic                o_mem_out_valid,
  output logic [15:0]         o_mem_burstlen
);
  typedef enum logic [1:0] {IDLE, LAT, BURST, GAP} state_t;
  state_t                 r_state, w_next;
  logic [DATABITS-1:0]    r_mem [2**MEMWORDBITS];
  logic [DATABITS-1:0]    r_mem_out;
  logic                   r_valid;
  logic [15:0]            r_lat_cnt, r_word_cnt;
  logic [MEMWORDBITS-1:0] r_base, w_addr_idx, w_rd_idx;
  logic                   w_last, w_unused;
  assign w_addr_idx = i_mem_addr[MEMWORDBITS+1:2];
  assign w_unused = ^{i_mem_addr[ADDRBITS-1:MEMWORDBITS+2], i_mem_addr[1:0]};
  assign w_rd_idx = r_base + MEMWORDBITS'(r_word_cnt);
  assign w_last = r_word_cnt == 16'(BURSTLEN - 1);
  assign o_mem_out = r_mem_out;
  assign o_mem_out_valid = r_valid;
  assign o_mem_burstlen = 16'(BURSTLEN);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = i_mem_rdreq ? (RDLATENCY == 1 ? BURST : LAT) : IDLE;
      // lat_cnt reaches 0 on the same edge that enters BURST
      LAT:     w_next = r_lat_cnt <= 16'd1 ? BURST : LAT;
      BURST:   w_next = w_last ? GAP : BURST;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_mem_wrreq) r_mem[w_addr_idx] <= i_mem_in;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= IDLE;
      r_lat_cnt  <= '0;
      r_word_cnt <= '0;
      r_base     <= '0;
      r_mem_out  <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_valid   <= r_state == BURST;
      // same-edge write is not yet visible here, so a colliding word returns old data
      r_mem_out <= r_state == BURST ? r_mem[w_rd_idx] : '0;
      if (r_state == IDLE && i_mem_rdreq) begin
        r_base     <= w_addr_idx;
        r_lat_cnt  <= 16'(RDLATENCY - 1);
        r_word_cnt <= '0;
      end else begin
        r_lat_cnt  <= r_state == LAT ? r_lat_cnt - 16'd1 : r_lat_cnt;
        r_word_cnt <= r_state == BURST ? r_word_cnt + 16'd1 : r_word_cnt;
      end
    end
  end
endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder: directed scenario tests for mem_burst_responder
module tb_mem_burst_responder;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_in = '0;
  logic        mem_wrreq = 1'b0;
  logic        mem_rdreq = 1'b0;
  logic [31:0] mem_out;
  logic        mem_out_valid;
  logic [15:0] mem_burstlen;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] got [32];
  int          ngot;

  mem_burst_responder dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_mem_addr(mem_addr), .i_mem_in(mem_in),
    .i_mem_wrreq(mem_wrreq), .i_mem_rdreq(mem_rdreq), .o_mem_out(mem_out),
    .o_mem_out_valid(mem_out_valid), .o_mem_burstlen(mem_burstlen)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    mem_addr = a;
    mem_in = d;
    mem_wrreq = 1'b1;
    @(negedge clk);
    mem_wrreq = 1'b0;
  endtask

  task automatic read_burst(input logic [31:0] a);
    mem_addr = a;
    mem_rdreq = 1'b1;
    @(negedge clk);
    mem_rdreq = 1'b0;
    ngot = 0;
    for (int c = 0; c < 40 && ngot < 16; c++) begin
      @(negedge clk);
      if (mem_out_valid) begin
        got[ngot] = mem_out;
        ngot++;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", mem_out_valid); end
    checks++; if (mem_out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", mem_out); end
    checks++; if (mem_burstlen !== 16'd16) begin errors++; $display("FAIL reset_burstlen: got %0d expected 16", mem_burstlen); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_burst;
    for (int i = 0; i < 16; i++) write_word(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    mem_addr = 32'h100;
    mem_rdreq = 1'b1;
    @(negedge clk);
    mem_rdreq = 1'b0;
    @(negedge clk);
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got valid %b expected 0 at E+1", mem_out_valid); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++; if (mem_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid[%0d]: got %b expected 1", i, mem_out_valid); end
      checks++; if (mem_out !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", i, mem_out, 32'hA000_0000 + 32'(i)); end
    end
    @(negedge clk);
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b expected 0", mem_out_valid); end
    checks++; if (mem_out !== 32'h0) begin errors++; $display("FAIL single_end_out: got %h expected 0", mem_out); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int n;
    int gap;
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) write_word(32'h140 + 32'(4 * i), 32'hB000_0000 + 32'(i));
    mem_addr = 32'h100;
    mem_rdreq = 1'b1;
    n = 0;
    gap = 0;
    for (int c = 0; c < 80 && n < 32; c++) begin
      @(negedge clk);
      if (mem_out_valid) begin
        got[n] = mem_out;
        n++;
        mem_addr = mem_addr + 32'd4;
        if (n == 17) mem_rdreq = 1'b0;
      end else if (n == 16) gap++;
    end
    mem_rdreq = 1'b0;
    checks++; if (n !== 32) begin errors++; $display("FAIL b2b_count: got %0d expected 32", n); end
    checks++; if (gap !== 3) begin errors++; $display("FAIL b2b_gap: got %0d expected 3", gap); end
    for (int i = 0; i < 32; i++) begin
      exp = i < 16 ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i - 16);
      checks++; if (got[i] !== exp) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got[i], exp); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap;
    logic [31:0] exp;
    for (int k = 0; k < 4; k++) write_word(32'hFF0 + 32'(4 * k), 32'hC000_0000 + 32'(k));
    // bit 12 lies above the word index, so 0x1000 aliases word 0
    for (int k = 0; k < 12; k++) write_word(32'h1000 + 32'(4 * k), 32'hD000_0000 + 32'(k));
    read_burst(32'hFF0);
    checks++; if (ngot !== 16) begin errors++; $display("FAIL wrap_count: got %0d expected 16", ngot); end
    for (int k = 0; k < 16; k++) begin
      exp = k < 4 ? 32'hC000_0000 + 32'(k) : 32'hD000_0000 + 32'(k - 4);
      checks++; if (got[k] !== exp) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, got[k], exp); end
    end
  endtask

  task automatic test_collision;
    int n;
    logic [31:0] exp;
    mem_addr = 32'h100;
    mem_rdreq = 1'b1;
    @(negedge clk);
    mem_rdreq = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 16; c++) begin
      // word 10 written at E+5 (read at E+12); word 12 written at E+14, its own read edge
      mem_wrreq = (c + 1 == 5) || (c + 1 == 14);
      mem_addr = c + 1 == 5 ? 32'h128 : 32'h130;
      mem_in = c + 1 == 5 ? 32'h5555_0000 : 32'h6666_0000;
      @(negedge clk);
      if (mem_out_valid) begin
        got[n] = mem_out;
        n++;
      end
    end
    mem_wrreq = 1'b0;
    checks++; if (n !== 16) begin errors++; $display("FAIL coll_count: got %0d expected 16", n); end
    for (int i = 0; i < 16; i++) begin
      exp = i == 10 ? 32'h5555_0000 : 32'hA000_0000 + 32'(i);
      checks++; if (got[i] !== exp) begin errors++; $display("FAIL coll_data[%0d]: got %h expected %h", i, got[i], exp); end
    end
    repeat (2) @(negedge clk);
    read_burst(32'h130);
    checks++; if (got[0] !== 32'h6666_0000) begin errors++; $display("FAIL coll_committed: got %h expected 66660000", got[0]); end
    write_word(32'h128, 32'hA000_000A);
    write_word(32'h130, 32'hA000_000C);
  endtask

  task automatic test_reset_mid_burst;
    int n;
    mem_addr = 32'h100;
    mem_rdreq = 1'b1;
    @(negedge clk);
    mem_rdreq = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 6; c++) begin
      @(negedge clk);
      if (mem_out_valid) n++;
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL rmid_reach: got %0d words expected 6", n); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", mem_out_valid); end
    checks++; if (mem_out !== 32'h0) begin errors++; $display("FAIL rmid_out: got %h expected 0", mem_out); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (mem_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b expected 0", mem_out_valid); end
    read_burst(32'h100);
    checks++; if (ngot !== 16) begin errors++; $display("FAIL rmid_count: got %0d expected 16", ngot); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (got[i] !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL rmid_data[%0d]: got %h expected %h", i, got[i], 32'hA000_0000 + 32'(i)); end
    end
  endtask

  initial begin
    test_reset;
    test_single_burst;
    test_back_to_back;
    test_wrap;
    test_collision;
    test_reset_mid_burst;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
